// File: rtl/aer_event_fifo.sv
// aer_event_fifo
// Elastic buffer sitting directly behind the AER packer. Each single-cycle
// event strobe captures one packed event word into a DEPTH-entry FIFO, and
// the readout side drains it over a valid/ready handshake with a
// first-word-fall-through head. The arbiter side cannot be back-pressured,
// so an event arriving while the FIFO is full (and nothing leaves that
// cycle) is discarded, counted in a saturating drop counter and latched
// in a sticky overflow flag.
//
// Ports:
//   clk_i          system clock, all state on the rising edge
//   reset_i        asynchronous active-high reset
//   ev_valid_i     one-cycle event strobe
//   ev_data_i      packed event word (DATA_W bits)
//   rd_ready_i     consumer accepts data_o this cycle
//   clear_i        synchronous clear of overflow_o and drop_cnt_o
//   data_o         head-of-FIFO word, 0 when empty
//   valid_o        data_o holds a valid word
//   count_o        current occupancy, 0..DEPTH
//   almost_full_o  count_o >= AF_LEVEL
//   full_o         count_o == DEPTH
//   overflow_o     at least one event dropped since reset or clear
//   drop_cnt_o     saturating count of dropped events

module aer_event_fifo #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int DROP_W   = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       ev_valid_i,
    input  logic [DATA_W-1:0]          ev_data_i,
    input  logic                       rd_ready_i,
    input  logic                       clear_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       almost_full_o,
    output logic                       full_o,
    output logic                       overflow_o,
    output logic [DROP_W-1:0]          drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     count;
    logic              push;
    logic              pop;
    logic              drop;

    // Pointers carry one extra wrap bit, so their difference is the exact
    // occupancy 0..DEPTH without needing a separate count register.
    assign count = wr_ptr - rd_ptr;

    // A full FIFO still accepts a push when the head leaves in the same
    // cycle; only an unmatched push into a full FIFO is dropped.
    assign pop  = valid_o && rd_ready_i;
    assign push = ev_valid_i && (!full_o || pop);
    assign drop = ev_valid_i && full_o && !pop;

    assign count_o       = count;
    assign valid_o       = (count != '0);
    assign full_o        = (count == PW'(DEPTH));
    assign almost_full_o = (count >= PW'(AF_LEVEL));
    assign data_o        = valid_o ? mem[rd_ptr[AW-1:0]] : '0;

    // Storage array is intentionally left out of reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= ev_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // A drop in the same cycle as clear_i wins: the cleared counter restarts
    // at one so the colliding drop is not lost.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (clear_i) begin
                drop_cnt_o <= DROP_W'(1);
            end else if (drop_cnt_o != '1) begin
                drop_cnt_o <= drop_cnt_o + DROP_W'(1);
            end
        end else if (clear_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end
    end

endmodule

// File: tb/tb_aer_event_fifo.sv
// tb_aer_event_fifo
// Directed bench for aer_event_fifo with DEPTH=4, AF_LEVEL=3, DROP_W=2.
// Inputs change 1 time unit after a rising edge and outputs are sampled
// at that same point, i.e. they show the effect of the preceding edge.

module tb_aer_event_fifo;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 4;
    localparam int AF_LEVEL = 3;
    localparam int DROP_W   = 2;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              ev_valid_i;
    logic [DATA_W-1:0] ev_data_i;
    logic              rd_ready_i;
    logic              clear_i;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic [2:0]        count_o;
    logic              almost_full_o;
    logic              full_o;
    logic              overflow_o;
    logic [DROP_W-1:0] drop_cnt_o;

    int vectors    = 0;
    int miscompares = 0;

    aer_event_fifo #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL),
        .DROP_W  (DROP_W)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .ev_valid_i   (ev_valid_i),
        .ev_data_i    (ev_data_i),
        .rd_ready_i   (rd_ready_i),
        .clear_i      (clear_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .count_o      (count_o),
        .almost_full_o(almost_full_o),
        .full_o       (full_o),
        .overflow_o   (overflow_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Apply one cycle of inputs, then land 1 unit after the next rising edge.
    task automatic drive_cycle(input logic ev, input logic [DATA_W-1:0] d,
                               input logic rdy, input logic clr);
        ev_valid_i = ev;
        ev_data_i  = d;
        rd_ready_i = rdy;
        clear_i    = clr;
        @(posedge clk_i);
        #1;
        ev_valid_i = 1'b0;
        rd_ready_i = 1'b0;
        clear_i    = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; ev_valid_i = 1'b0; ev_data_i = '0; rd_ready_i = 1'b0; clear_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #3 reset_i = 1'b0;
        @(posedge clk_i); #1;
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %0b want 0", valid_o); end
        vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", count_o); end
        vectors++; if (data_o !== 32'h0) begin miscompares++; $display("FAIL rst_data: got %h want 0", data_o); end
        vectors++; if ({full_o, almost_full_o, overflow_o} !== 3'b000) begin miscompares++; $display("FAIL rst_flags: got %b want 000", {full_o, almost_full_o, overflow_o}); end
        vectors++; if (drop_cnt_o !== 2'd0) begin miscompares++; $display("FAIL rst_drop: got %0d want 0", drop_cnt_o); end
    endtask

    task automatic test_latency();
        drive_cycle(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL lat_valid: got %0b want 1", valid_o); end
        vectors++; if (data_o !== 32'hA5A5_0001) begin miscompares++; $display("FAIL lat_data: got %h want a5a50001", data_o); end
        vectors++; if (count_o !== 3'd1) begin miscompares++; $display("FAIL lat_count: got %0d want 1", count_o); end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL lat_pop_valid: got %0b want 0", valid_o); end
        vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL lat_pop_count: got %0d want 0", count_o); end
        // rd_ready_i while empty must not move the read pointer.
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        drive_cycle(1'b1, 32'hC0DE_0002, 1'b0, 1'b0);
        vectors++; if (data_o !== 32'hC0DE_0002) begin miscompares++; $display("FAIL empty_rd_data: got %h want c0de0002", data_o); end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL empty_rd_count: got %0d want 0", count_o); end
    endtask

    task automatic test_fill_overflow();
        logic [DATA_W-1:0] exp_words [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        drive_cycle(1'b1, 32'h11, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h22, 1'b0, 1'b0);
        vectors++; if (almost_full_o !== 1'b0) begin miscompares++; $display("FAIL af_after2: got %0b want 0", almost_full_o); end
        drive_cycle(1'b1, 32'h33, 1'b0, 1'b0);
        vectors++; if ({almost_full_o, full_o} !== 2'b10) begin miscompares++; $display("FAIL af_after3: got %b want 10", {almost_full_o, full_o}); end
        drive_cycle(1'b1, 32'h44, 1'b0, 1'b0);
        vectors++; if ({almost_full_o, full_o, overflow_o} !== 3'b110) begin miscompares++; $display("FAIL full_after4: got %b want 110", {almost_full_o, full_o, overflow_o}); end
        drive_cycle(1'b1, 32'h55, 1'b0, 1'b0);
        vectors++; if ({overflow_o, drop_cnt_o} !== 3'b101) begin miscompares++; $display("FAIL drop_first: got %b want 101", {overflow_o, drop_cnt_o}); end
        drive_cycle(1'b1, 32'h66, 1'b0, 1'b0);
        vectors++; if (drop_cnt_o !== 2'd2) begin miscompares++; $display("FAIL drop_cnt: got %0d want 2", drop_cnt_o); end
        vectors++; if (count_o !== 3'd4) begin miscompares++; $display("FAIL drop_count: got %0d want 4", count_o); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (data_o !== exp_words[i]) begin miscompares++; $display("FAIL fill_drain[%0d]: got %h want %h", i, data_o, exp_words[i]); end
            drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        end
        vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL fill_drain_count: got %0d want 0", count_o); end
    endtask

    task automatic test_full_push_pop();
        logic [DATA_W-1:0] exp_words [4] = '{32'h22, 32'h33, 32'h44, 32'h77};
        drive_cycle(1'b1, 32'h11, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h22, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h33, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h44, 1'b0, 1'b0);
        vectors++; if (data_o !== 32'h11) begin miscompares++; $display("FAIL fpp_head: got %h want 11", data_o); end
        drive_cycle(1'b1, 32'h77, 1'b1, 1'b0);
        vectors++; if (count_o !== 3'd4) begin miscompares++; $display("FAIL fpp_count: got %0d want 4", count_o); end
        vectors++; if (drop_cnt_o !== 2'd2) begin miscompares++; $display("FAIL fpp_drop: got %0d want 2", drop_cnt_o); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (data_o !== exp_words[i]) begin miscompares++; $display("FAIL fpp_drain[%0d]: got %h want %h", i, data_o, exp_words[i]); end
            drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b1, 32'h100, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h101, 1'b0, 1'b0);
        for (int i = 2; i < 12; i++) begin
            vectors++; if (data_o !== DATA_W'(32'h100 + i - 2)) begin miscompares++; $display("FAIL b2b_head[%0d]: got %h want %h", i, data_o, 32'h100 + i - 2); end
            drive_cycle(1'b1, DATA_W'(32'h100 + i), 1'b1, 1'b0);
            vectors++; if (count_o !== 3'd2) begin miscompares++; $display("FAIL b2b_count[%0d]: got %0d want 2", i, count_o); end
        end
        vectors++; if (data_o !== 32'h10A) begin miscompares++; $display("FAIL b2b_tail0: got %h want 10a", data_o); end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        vectors++; if (data_o !== 32'h10B) begin miscompares++; $display("FAIL b2b_tail1: got %h want 10b", data_o); end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL b2b_empty: got %0b want 0", valid_o); end
    endtask

    task automatic test_clear_drop();
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, DATA_W'(32'h200 + i), 1'b0, 1'b0);
        drive_cycle(1'b1, 32'hDEAD, 1'b0, 1'b0);
        vectors++; if ({overflow_o, drop_cnt_o} !== 3'b111) begin miscompares++; $display("FAIL clr_setup: got %b want 111", {overflow_o, drop_cnt_o}); end
        drive_cycle(1'b1, 32'hDEAD, 1'b0, 1'b1);
        vectors++; if ({overflow_o, drop_cnt_o} !== 3'b101) begin miscompares++; $display("FAIL clr_collide: got %b want 101", {overflow_o, drop_cnt_o}); end
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++; if ({overflow_o, drop_cnt_o} !== 3'b000) begin miscompares++; $display("FAIL clr_alone: got %b want 000", {overflow_o, drop_cnt_o}); end
        vectors++; if (count_o !== 3'd4 || data_o !== 32'h200) begin miscompares++; $display("FAIL clr_fifo: got count %0d head %h want 4 200", count_o, data_o); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 32'hBAD, 1'b0, 1'b0);
        vectors++; if ({overflow_o, drop_cnt_o} !== 3'b111) begin miscompares++; $display("FAIL sat_cnt: got %b want 111", {overflow_o, drop_cnt_o}); end
        vectors++; if (data_o !== 32'h200) begin miscompares++; $display("FAIL sat_head: got %h want 200", data_o); end
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        vectors++; if ({count_o, almost_full_o} !== 4'b0111) begin miscompares++; $display("FAIL ar_pre: got %b want 0111", {count_o, almost_full_o}); end
        #3 reset_i = 1'b1;
        #1;
        vectors++; if ({valid_o, full_o, almost_full_o, overflow_o} !== 4'b0000) begin miscompares++; $display("FAIL ar_flags: got %b want 0000", {valid_o, full_o, almost_full_o, overflow_o}); end
        vectors++; if (count_o !== 3'd0 || drop_cnt_o !== 2'd0 || data_o !== 32'h0) begin miscompares++; $display("FAIL ar_values: got count %0d drop %0d data %h want 0 0 0", count_o, drop_cnt_o, data_o); end
        #1 reset_i = 1'b0;
        @(posedge clk_i); #1;
        drive_cycle(1'b1, 32'hBEEF, 1'b0, 1'b0);
        vectors++; if (data_o !== 32'hBEEF || count_o !== 3'd1) begin miscompares++; $display("FAIL ar_first: got data %h count %0d want beef 1", data_o, count_o); end
        drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL ar_drain: got %0b want 0", valid_o); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_clear_drop();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aer_event_fifo.md
Name: aer_event_fifo

Overview:
- Elastic buffer directly downstream of the AER packer.
- Captures each packed event word (timestamp, row, column, polarity) on a single-cycle event strobe and holds it in a DEPTH-entry FIFO.
- Presents words to the readout interface over a valid/ready handshake.
- The arbiter side cannot be stalled, so on overflow the block drops the incoming event, counts it and flags it, and gives early warning via almost_full.

Parameters:
- DATA_W, 32, width of one event word; instantiate with WIDTH from arbiter_pkg.
- DEPTH, 16, number of entries; power of two, minimum 2.
- AF_LEVEL, 12, almost_full_o asserts when count_o >= AF_LEVEL; range 1..DEPTH.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk_i  input  1  system clock, all state on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- ev_valid_i  input  1  one-cycle strobe; the event word is valid this cycle.
- ev_data_i  input  DATA_W  packed event word from the AER packer.
- rd_ready_i  input  1  consumer accepts data_o this cycle.
- data_o  output  DATA_W  head-of-FIFO event word.
- valid_o  output  1  data_o holds a valid word.
- count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full_o  output  1  count_o >= AF_LEVEL.
- full_o  output  1  count_o == DEPTH.
- overflow_o  output  1  sticky flag; at least one event dropped since reset or clear.
- drop_cnt_o  output  DROP_W  number of dropped events, saturating.
- clear_i  input  1  synchronous clear of overflow_o and drop_cnt_o only.

Behaviour:
- Reset (asynchronous, reset_i=1): write and read pointers 0, count 0, valid_o=0, full_o=0, almost_full_o=0, overflow_o=0, drop_cnt_o=0, data_o=0.
  - Memory contents are not reset.
  - Reset mid-stream discards all buffered events immediately, with no drain.
- Storage: DEPTH x DATA_W register array. Write and read pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty on wrap-around.
- Push: ev_valid_i=1 and (count<DEPTH or pop in the same cycle).
  - The word is written at wr_ptr and wr_ptr increments.
- Pop: valid_o=1 and rd_ready_i=1; rd_ptr increments.
- Output path is first-word-fall-through.
  - valid_o = (count != 0).
  - data_o = mem[rd_ptr]; drive 0 when empty.
- Latency: an event pushed into an empty FIFO at edge N shows valid_o=1 with that word in the cycle after edge N (1 cycle).
- count_o update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - neither: unchanged.
- Full with simultaneous push and pop: both happen, count stays DEPTH, nothing is dropped.
- Empty with push: no pop is possible that cycle (valid_o=0), so count becomes 1.
- Drop condition: ev_valid_i=1, count==DEPTH and no pop that cycle.
  - The word is discarded and the FIFO is unchanged.
  - overflow_o is set next cycle.
  - drop_cnt_o increments, saturating at 2^DROP_W-1.
- clear_i=1: overflow_o and drop_cnt_o go to 0 next cycle.
  - If a drop occurs in the same cycle, the drop wins: overflow_o=1 and drop_cnt_o=1.
  - clear_i does not affect FIFO contents or pointers.
- rd_ready_i while empty: ignored, no pointer movement.
- full_o and almost_full_o are combinational from the registered count.
- Ordering is strictly FIFO; words are never reordered or duplicated.

Test Plan:
- Basic latency (DEPTH=4): reset, then push 0xA5A5_0001 at edge 1 with rd_ready_i=0 -> valid_o=1 and data_o=0xA5A5_0001 from edge 1; count_o=1; pop -> valid_o=0, count_o=0.
- Fill and overflow (DEPTH=4, AF_LEVEL=3): push 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 on consecutive cycles, no reads.
  - almost_full_o rises after the 3rd push; full_o after the 4th.
  - 0x55 and 0x66 are dropped: drop_cnt_o=2, overflow_o=1.
  - Drain yields 0x11, 0x22, 0x33, 0x44.
- Full with push and pop together: with FIFO full of 0x11..0x44, push 0x77 with rd_ready_i=1 -> 0x11 is read, count_o stays 4, drop_cnt_o unchanged; drain yields 0x22, 0x33, 0x44, 0x77.
- Pointer wrap: 10 cycles of push+pop in steady state at count=2 (DEPTH=4), with incrementing data -> output sequence is exactly in order, count_o=2 throughout.
- Clear vs drop collision: with overflow_o=1 and drop_cnt_o=3, assert clear_i in the same cycle as a drop -> overflow_o=1 and drop_cnt_o=1; clear_i alone -> both become 0.
- Async reset mid-stream: with 3 words buffered, assert reset_i between clock edges -> all outputs go to 0 immediately without a clock edge; after release, the first new push is the first word read.
- Drop counter saturation (DROP_W=2): 5 drops -> drop_cnt_o holds at 3.
